// File: rtl/sa_pkg.sv
// Shared types and width helpers for the weight-stationary systolic tile.
package sa_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } sa_state_e;

    // Bits needed to count from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Processing element: multiply-accumulate against a stationary weight,
// registering the activation (passed right) and the psum (passed down).
module sa_pe
    import sa_pkg::*;
#(
    parameter int ADD_DATAWIDTH = 32,
    parameter int MUL_DATAWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [MUL_DATAWIDTH-1:0] i_act,
    input  logic [MUL_DATAWIDTH-1:0] i_weight,
    input  logic [ADD_DATAWIDTH-1:0] i_psum,
    output logic [MUL_DATAWIDTH-1:0] o_act,
    output logic [ADD_DATAWIDTH-1:0] o_psum
);

    logic signed [ADD_DATAWIDTH-1:0] w_act_ext;
    logic signed [ADD_DATAWIDTH-1:0] w_wgt_ext;
    logic        [ADD_DATAWIDTH-1:0] w_prod;

    // Sign-extend both operands so the product wraps modulo 2^ADD_DATAWIDTH.
    assign w_act_ext = ADD_DATAWIDTH'($signed(i_act));
    assign w_wgt_ext = ADD_DATAWIDTH'($signed(i_weight));
    assign w_prod    = w_act_ext * w_wgt_ext;

    // Register the forwarded activation and the accumulated psum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_act  <= '0;
            o_psum <= '0;
        end else begin
            o_act  <= i_act;
            o_psum <= i_psum + w_prod;
        end
    end

endmodule

// File: rtl/sa_skew.sv
// Fixed-depth delay line used for activation/psum skew and output deskew.
// DEPTH=0 degenerates to a plain wire.
module sa_skew
    import sa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset are not needed by a zero-length line.
            logic w_clk_unused;
            assign w_clk_unused = clk & rst_n;
            assign o_data       = i_data;
        end else begin : g_regs
            logic [WIDTH-1:0] r_line [DEPTH];

            // Advance the line one stage per cycle; the last stage drives the output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) r_line[k] <= '0;
                end else begin
                    r_line[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) r_line[k] <= r_line[k-1];
                end
            end

            assign o_data = r_line[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_tile.sv
// Self-sequencing weight-stationary systolic tile: weight load, skewed
// compute with valid tagging, deskewed column-aligned output and drain.
module sa_tile
    import sa_pkg::*;
#(
    parameter int ADD_DATAWIDTH = 32,
    parameter int MUL_DATAWIDTH = 8,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start_load,
    input  logic                              i_weight_valid,
    input  logic [MUL_DATAWIDTH*NUM_COLS-1:0] i_weight,
    input  logic                              i_act_valid,
    output logic                              o_act_ready,
    input  logic [MUL_DATAWIDTH*NUM_ROWS-1:0] i_act,
    input  logic [ADD_DATAWIDTH*NUM_COLS-1:0] i_psum,
    input  logic                              i_accumulate,
    input  logic                              i_last,
    output logic                              o_valid,
    output logic [ADD_DATAWIDTH*NUM_COLS-1:0] o_psum,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int LATENCY = NUM_ROWS + NUM_COLS;
    localparam int WCNT_W  = cnt_width(NUM_ROWS);
    localparam int DCNT_W  = cnt_width(LATENCY);
    localparam int MW      = MUL_DATAWIDTH;
    localparam int AW      = ADD_DATAWIDTH;

    sa_state_e           r_state;
    sa_state_e           w_next_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [DCNT_W-1:0]   r_dcnt;
    logic                r_act_ready;
    logic                r_busy;
    logic                r_done;
    logic [LATENCY-1:0]  r_vpipe;
    logic [MW*NUM_COLS-1:0] r_w [NUM_ROWS];
    logic [AW*NUM_COLS-1:0] r_opsum;
    logic                w_accept;
    logic                w_wbeat;

    logic [MW-1:0] w_act_in   [NUM_ROWS];
    logic [AW-1:0] w_psum_in  [NUM_COLS];
    logic [MW-1:0] w_act_h    [NUM_ROWS][NUM_COLS];
    logic [MW-1:0] w_act_unused [NUM_ROWS];
    logic [AW-1:0] w_psum_v   [NUM_ROWS+1][NUM_COLS];
    logic [AW-1:0] w_desk     [NUM_COLS];

    assign w_accept = i_act_valid & r_act_ready;
    assign w_wbeat  = (r_state == S_LOAD) & i_weight_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode for the load/compute/drain sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_start_load) w_next_state = S_LOAD;
                       else              w_next_state = S_IDLE;
            S_LOAD:    if (w_wbeat && (r_wcnt == WCNT_W'(NUM_ROWS - 1))) w_next_state = S_COMPUTE;
                       else                                              w_next_state = S_LOAD;
            S_COMPUTE: if (w_accept && i_last) w_next_state = S_DRAIN;
                       else                    w_next_state = S_COMPUTE;
            S_DRAIN:   if (r_dcnt == DCNT_W'(LATENCY - 1)) w_next_state = S_IDLE;
                       else                                w_next_state = S_DRAIN;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Weight-beat and drain counters plus the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt      <= '0;
            r_dcnt      <= '0;
            r_act_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wcnt      <= (r_state != S_LOAD) ? '0 : (w_wbeat ? r_wcnt + WCNT_W'(1) : r_wcnt);
            r_dcnt      <= (r_state == S_DRAIN) ? r_dcnt + DCNT_W'(1) : '0;
            r_act_ready <= (r_state == S_COMPUTE) && !(w_accept && i_last);
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (r_state == S_DRAIN) && (r_dcnt == DCNT_W'(LATENCY - 2));
        end
    end

    // Weight shift chain: newest beat enters row 0, older beats move down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_ROWS; j++) r_w[j] <= '0;
        end else if (w_wbeat) begin
            r_w[0] <= i_weight;
            for (int j = 1; j < NUM_ROWS; j++) r_w[j] <= r_w[j-1];
        end
    end

    // Valid tag travelling alongside each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vpipe <= '0;
        else        r_vpipe <= {r_vpipe[LATENCY-2:0], w_accept};
    end

    // Final output register after the deskew lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opsum <= '0;
        end else begin
            for (int i = 0; i < NUM_COLS; i++) r_opsum[i*AW +: AW] <= w_desk[i];
        end
    end

    genvar gj, gi;
    generate
        for (gj = 0; gj < NUM_ROWS; gj++) begin : g_row
            // Bubbles inject zeros so idle cycles cannot disturb results.
            assign w_act_in[gj] = w_accept ? i_act[gj*MW +: MW] : '0;
            sa_skew #(.WIDTH(MW), .DEPTH(gj)) u_act_skew (
                .clk(clk), .rst_n(rst_n), .i_data(w_act_in[gj]), .o_data(w_act_h[gj][0])
            );
            for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
                if (gi == NUM_COLS - 1) begin : g_edge
                    sa_pe #(.ADD_DATAWIDTH(AW), .MUL_DATAWIDTH(MW)) u_pe (
                        .clk(clk), .rst_n(rst_n),
                        .i_act(w_act_h[gj][gi]), .i_weight(r_w[gj][gi*MW +: MW]),
                        .i_psum(w_psum_v[gj][gi]),
                        .o_act(w_act_unused[gj]), .o_psum(w_psum_v[gj+1][gi])
                    );
                end else begin : g_inner
                    sa_pe #(.ADD_DATAWIDTH(AW), .MUL_DATAWIDTH(MW)) u_pe (
                        .clk(clk), .rst_n(rst_n),
                        .i_act(w_act_h[gj][gi]), .i_weight(r_w[gj][gi*MW +: MW]),
                        .i_psum(w_psum_v[gj][gi]),
                        .o_act(w_act_h[gj][gi+1]), .o_psum(w_psum_v[gj+1][gi])
                    );
                end
            end
        end
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_colio
            assign w_psum_in[gi] = (w_accept && i_accumulate) ? i_psum[gi*AW +: AW] : '0;
            sa_skew #(.WIDTH(AW), .DEPTH(gi)) u_psum_skew (
                .clk(clk), .rst_n(rst_n), .i_data(w_psum_in[gi]), .o_data(w_psum_v[0][gi])
            );
            sa_skew #(.WIDTH(AW), .DEPTH(NUM_COLS - 1 - gi)) u_deskew (
                .clk(clk), .rst_n(rst_n), .i_data(w_psum_v[NUM_ROWS][gi]), .o_data(w_desk[gi])
            );
        end
    endgenerate

    assign o_act_ready = r_act_ready;
    assign o_valid     = r_vpipe[LATENCY-1];
    assign o_psum      = r_opsum;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_sa_tile.sv
// Randomised self-checking bench for sa_tile against a matrix-vector model.
module tb_sa_tile;

    localparam int MW = 8;
    localparam int AW = 32;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int L  = R + C;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start_load, i_weight_valid, i_act_valid;
    logic              i_accumulate, i_last;
    logic [MW*C-1:0]   i_weight;
    logic [MW*R-1:0]   i_act;
    logic [AW*C-1:0]   i_psum;
    logic              o_act_ready, o_valid, o_busy, o_done;
    logic [AW*C-1:0]   o_psum;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [MW-1:0]   W [R][C];
    int              exp_cyc [$];
    logic [AW*C-1:0] exp_val [$];
    int              obs_cyc [$];
    logic [AW*C-1:0] obs_val [$];
    int              done_cyc [$];

    sa_tile #(.ADD_DATAWIDTH(AW), .MUL_DATAWIDTH(MW), .NUM_ROWS(R), .NUM_COLS(C)) dut (
        .clk(clk), .rst_n(rst_n), .i_start_load(i_start_load),
        .i_weight_valid(i_weight_valid), .i_weight(i_weight),
        .i_act_valid(i_act_valid), .o_act_ready(o_act_ready), .i_act(i_act),
        .i_psum(i_psum), .i_accumulate(i_accumulate), .i_last(i_last),
        .o_valid(o_valid), .o_psum(o_psum), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_val.push_back(o_psum);
        end
        if (o_done === 1'b1) done_cyc.push_back(cyc);
    end

    // Column i result = (acc ? psum_i : 0) + sum_j act_j * W[j][i], modulo 2^AW.
    function automatic logic [AW*C-1:0] model(input logic [MW*R-1:0] a,
                                              input logic [AW*C-1:0] p, input bit acc);
        logic [AW*C-1:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < C; i++) begin
            s = acc ? longint'(p[i*AW +: AW]) : 64'sd0;
            for (int j = 0; j < R; j++)
                s = s + longint'($signed(a[j*MW +: MW])) * longint'($signed(W[j][i]));
            r[i*AW +: AW] = AW'(s);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_cyc.delete(); exp_val.delete();
        obs_cyc.delete(); obs_val.delete(); done_cyc.delete();
    endtask

    task automatic idle_inputs();
        i_start_load = 1'b0; i_weight_valid = 1'b0; i_act_valid = 1'b0;
        i_accumulate = 1'b0; i_last = 1'b0;
        i_weight = '0; i_act = '0; i_psum = '0;
    endtask

    // Weight beat b lands in row R-1-b; random hold-off gaps in between.
    task automatic do_load(input logic [MW*C-1:0] bt [R], input int gap_pct);
        i_start_load = 1'b1;
        tick();
        i_start_load = 1'b0;
        for (int b = 0; b < R; b++) begin
            while ($urandom_range(99) < gap_pct) begin
                i_weight_valid = 1'b0; i_weight = $urandom;
                tick();
            end
            i_weight_valid = 1'b1; i_weight = bt[b];
            for (int i = 0; i < C; i++) W[R-1-b][i] = bt[b][i*MW +: MW];
            tick();
        end
        i_weight_valid = 1'b0;
    endtask

    task automatic rand_load(input int gap_pct);
        logic [MW*C-1:0] bt [R];
        for (int b = 0; b < R; b++) bt[b] = $urandom;
        do_load(bt, gap_pct);
        tick();
    endtask

    task automatic drive_beat(input logic [MW*R-1:0] a, input logic [AW*C-1:0] p,
                              input bit acc, input bit last, output int beat_cyc);
        i_act_valid = 1'b1; i_act = a; i_psum = p; i_accumulate = acc; i_last = last;
        i_start_load = 1'($urandom_range(1)); i_weight_valid = 1'($urandom_range(1));
        i_weight = $urandom;
        exp_cyc.push_back(cyc + L);
        exp_val.push_back(model(a, p, acc));
        beat_cyc = cyc;
        tick();
        idle_inputs();
    endtask

    task automatic drive_bubble();
        i_act_valid = 1'b0; i_act = $urandom; i_psum = {$urandom, $urandom, $urandom, $urandom};
        i_accumulate = 1'($urandom_range(1)); i_last = 1'($urandom_range(1));
        i_start_load = 1'($urandom_range(1)); i_weight_valid = 1'($urandom_range(1));
        i_weight = $urandom;
        tick();
        idle_inputs();
    endtask

    task automatic rand_pass(input int nbeats, input int gap_pct, output int last_cyc);
        int c;
        for (int b = 0; b < nbeats; b++) begin
            while ($urandom_range(99) < gap_pct) drive_bubble();
            drive_beat($urandom, {$urandom, $urandom, $urandom, $urandom},
                       1'($urandom_range(1)), b == nbeats - 1, c);
            last_cyc = c;
        end
    endtask

    task automatic test_reset();
        n_tests++; if (o_act_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_act_ready); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_tests++; if (o_psum !== '0) begin n_fail++; $display("FAIL reset_psum: got %h want 0", o_psum); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
    endtask

    task automatic test_directed();
        logic [MW*C-1:0] bt [R];
        int lc;
        clear_q();
        bt[0] = '0; bt[1] = '0; bt[2] = 32'h0000_0403; bt[3] = 32'h0000_0201;
        do_load(bt, 30);
        n_tests++; if (o_act_ready !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL dir_ready_early: got rdy %b busy %b want 0 1", o_act_ready, o_busy); end
        tick();
        n_tests++; if (o_act_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready_rise: got %b want 1", o_act_ready); end
        drive_beat(32'h0000_0605, '0, 1'b0, 1'b1, lc);
        n_tests++; if (o_act_ready !== 1'b0) begin n_fail++; $display("FAIL dir_ready_fall: got %b want 0", o_act_ready); end
        repeat (L - 1) tick();
        i_start_load = 1'b1;
        tick();
        i_start_load = 1'b0;
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL dir_start_at_done: got busy %b want 0", o_busy); end
        repeat (3) tick();
        n_tests++;
        if (obs_cyc.size() != 1 || obs_cyc[0] != lc + L || obs_val[0] !== {64'd0, 32'd34, 32'd23}) begin
            n_fail++; $display("FAIL dir_result: got n=%0d val %h want cyc %0d val 34/23", obs_cyc.size(), obs_val.size() ? obs_val[0] : '0, lc + L);
        end
        n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != lc + L) begin n_fail++; $display("FAIL dir_done: got n=%0d want one at %0d", done_cyc.size(), lc + L); end

        // Accumulate with the same weights reloaded.
        clear_q();
        do_load(bt, 0);
        tick();
        drive_beat(32'h0000_0605, {64'd0, 32'hFFFF_FF9C, 32'd100}, 1'b1, 1'b1, lc);
        repeat (L + 2) tick();
        n_tests++;
        if (obs_val.size() != 1 || obs_val[0] !== {64'd0, 32'hFFFF_FFBE, 32'd123}) begin
            n_fail++; $display("FAIL acc_result: got n=%0d val %h want -66/123", obs_val.size(), obs_val.size() ? obs_val[0] : '0);
        end
    endtask

    task automatic test_signed_wrap();
        logic [MW*C-1:0] bt [R];
        int lc;
        clear_q();
        for (int b = 0; b < R; b++) bt[b] = 32'h8080_8080;
        do_load(bt, 0);
        tick();
        drive_beat(32'h8080_8080, '0, 1'b0, 1'b0, lc);
        drive_beat(32'h8080_8080, {4{32'h7FFF_FFFF}}, 1'b1, 1'b1, lc);
        repeat (L + 2) tick();
        n_tests++;
        if (obs_val.size() != 2 || obs_val[0] !== {4{32'h0001_0000}} || obs_val[1] !== {4{32'h8000_FFFF}}
            || obs_cyc[1] != obs_cyc[0] + 1) begin
            n_fail++; $display("FAIL signed_wrap: got n=%0d v0 %h v1 %h want 00010000 / 8000ffff back-to-back",
                               obs_val.size(), obs_val.size() > 0 ? obs_val[0] : '0, obs_val.size() > 1 ? obs_val[1] : '0);
        end
    endtask

    task automatic test_random(input int gap_pct, input int nbeats, input string tag);
        int lc;
        clear_q();
        rand_load(40);
        rand_pass(nbeats, gap_pct, lc);
        repeat (L + 3) tick();
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++; $display("FAIL %s_count: got %0d results want %0d", tag, obs_cyc.size(), exp_cyc.size());
        end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            n_tests++;
            if (obs_cyc[k] != exp_cyc[k] || obs_val[k] !== exp_val[k]) begin
                n_fail++; $display("FAIL %s_beat%0d: got cyc %0d val %h want cyc %0d val %h",
                                   tag, k, obs_cyc[k], obs_val[k], exp_cyc[k], exp_val[k]);
            end
        end
        n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != lc + L) begin n_fail++; $display("FAIL %s_done: got n=%0d want one at %0d", tag, done_cyc.size(), lc + L); end
        n_tests++; if (o_busy !== 1'b0 || o_act_ready !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got busy %b rdy %b want 0 0", tag, o_busy, o_act_ready); end
    endtask

    task automatic test_protocol();
        int bad = 0;
        clear_q();
        for (int k = 0; k < 6; k++) begin
            i_act_valid = 1'b1; i_act = $urandom; i_last = 1'b1;
            i_weight_valid = 1'b1; i_weight = $urandom;
            tick();
            if (o_act_ready !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        idle_inputs();
        repeat (L + 2) tick();
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_ignore: got %0d cycles with ready/busy set want 0", bad); end
        n_tests++; if (obs_cyc.size() != 0 || done_cyc.size() != 0) begin n_fail++; $display("FAIL idle_no_output: got %0d valid %0d done want 0 0", obs_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_reset_mid_drain();
        int lc;
        clear_q();
        rand_load(0);
        rand_pass(3, 0, lc);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_psum !== '0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_act_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_drain_outputs: got v%b d%b b%b r%b psum %h want all 0", o_valid, o_done, o_busy, o_act_ready, o_psum);
        end
        tick();
        rst_n = 1'b1;
        obs_cyc.delete(); obs_val.delete(); done_cyc.delete();
        repeat (L + 4) tick();
        n_tests++; if (obs_cyc.size() != 0 || done_cyc.size() != 0) begin n_fail++; $display("FAIL rst_drain_dropped: got %0d valid %0d done want 0 0", obs_cyc.size(), done_cyc.size()); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_directed();
        test_signed_wrap();
        test_protocol();
        test_random(40, 3, "bubbles");
        test_random(0, 10, "b2b");
        test_random(30, 8, "mixed");
        test_reset_mid_drain();
        test_random(25, 6, "post_reset");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
